// File: rtl/sdram_aref.sv
// SDRAM auto-refresh controller: a periodic interval timer raises a refresh request.
// Once the arbiter grants the bus, the block issues PRECHARGE-all and then two AUTO REFRESH commands.
module sdram_aref #(
  parameter int REF_PERIOD = 750,
  parameter int T_RP       = 2,
  parameter int T_RC       = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_init_end,
  input  logic        ref_en,
  output logic        ref_req,
  output logic        flag_ref_end,
  output logic [3:0]  aref_cmd,
  output logic [11:0] aref_addr,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int TW   = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam int WMAX = (T_RP > T_RC) ? T_RP : T_RC;
  localparam int CW   = $clog2(WMAX + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(REF_PERIOD - 1);
  localparam logic [CW-1:0] RP_LAST    = CW'(T_RP - 1);
  localparam logic [CW-1:0] RC_LAST    = CW'(T_RC - 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE      = 3'd1,
    S_WAIT_RP  = 3'd2,
    S_AREF1    = 3'd3,
    S_WAIT_RC1 = 3'd4,
    S_AREF2    = 3'd5,
    S_WAIT_RC2 = 3'd6,
    S_END      = 3'd7
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt;
  logic          expire;

  assign dbg_state = state;
  assign expire    = flag_init_end && (timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (!flag_init_end || timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Handshake: ref_req stays high until the edge where ref_req && ref_en are both
  // sampled high; that edge enters PRE and drops ref_req. A grant-edge expiry is not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ref_req      <= 1'b0;
      flag_ref_end <= 1'b0;
      aref_cmd     <= CMD_NOP;
      aref_addr    <= 12'h000;
    end else begin
      flag_ref_end <= 1'b0;
      aref_cmd     <= CMD_NOP;
      aref_addr    <= 12'h000;
      if (expire) ref_req <= 1'b1;
      case (state)
        S_IDLE: begin
          if (ref_req && ref_en) begin
            state     <= S_PRE;
            ref_req   <= 1'b0;
            aref_cmd  <= CMD_PRE;
            aref_addr <= 12'h400;
          end
        end
        S_PRE: begin
          state <= S_WAIT_RP;
          cnt   <= '0;
        end
        S_WAIT_RP: begin
          if (cnt == RP_LAST) begin
            state    <= S_AREF1;
            aref_cmd <= CMD_AREF;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_AREF1: begin
          state <= S_WAIT_RC1;
          cnt   <= '0;
        end
        S_WAIT_RC1: begin
          if (cnt == RC_LAST) begin
            state    <= S_AREF2;
            aref_cmd <= CMD_AREF;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_AREF2: begin
          state <= S_WAIT_RC2;
          cnt   <= '0;
        end
        S_WAIT_RC2: begin
          if (cnt == RC_LAST) begin
            state        <= S_END;
            flag_ref_end <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_END: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_aref.md
SDRAM_AREF -- requirements
Module: sdram_aref

Interface
REQ-001 Parameter REF_PERIOD, default 750, refresh interval in clk cycles (15 us at 50 MHz; 4096 rows per 64 ms).
REQ-002 Parameter T_RP, default 2, NOP cycles between PRECHARGE and first AUTO REFRESH.
REQ-003 Parameter T_RC, default 7, cycle spacing between AUTO REFRESH commands and from the last one to completion.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flag_init_end  input  1  level, high once SDRAM power-up initialisation has completed.
REQ-007 ref_en  input  1  grant from the command arbiter allowing this block to drive the SDRAM bus.
REQ-008 ref_req  output  1  refresh request to the arbiter.
REQ-009 flag_ref_end  output  1  one-cycle pulse marking completion of a refresh sequence.
REQ-010 aref_cmd  output  4  command {cs_n,ras_n,cas_n,we_n}: NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001.
REQ-011 aref_addr  output  12  SDRAM address bus value during the sequence.

Function
REQ-012 Interval timer shall be held at 0 while flag_init_end is low, and shall count 0..REF_PERIOD-1 and wrap while flag_init_end is high.
REQ-013 The cycle the timer equals REF_PERIOD-1, ref_req shall be set on the next edge and stay high until a grant is taken.
REQ-014 Timer shall keep running during a pending request and during a sequence; an expiry while ref_req is already high shall not queue a second request.
REQ-015 Timer expiry during an active sequence shall set ref_req again on the following edge (the new request is served after the current sequence ends).
REQ-016 States: IDLE, PRE, WAIT_RP, AREF1, WAIT_RC1, AREF2, WAIT_RC2, END.
REQ-017 IDLE -> PRE when ref_req and ref_en are both high at a rising edge; ref_en without ref_req shall be ignored.
REQ-018 ref_req shall clear on the same edge that enters PRE.
REQ-019 Sequence timing, cycle 0 = PRE: PRECHARGE at cycle 0 with aref_addr = 12'h400 (A10=1, all banks); NOP cycles 1..T_RP; AUTO REFRESH at cycle T_RP+1; NOP for T_RC-1 cycles; AUTO REFRESH at cycle T_RP+1+T_RC; NOP for T_RC-1 cycles; END at cycle T_RP+1+2*T_RC.
REQ-020 In END, flag_ref_end shall be high for exactly that one cycle with aref_cmd = NOP; next state IDLE.
REQ-021 aref_cmd shall be NOP and aref_addr 12'h000 in every cycle other than the PRECHARGE and AUTO REFRESH cycles.
REQ-022 All outputs shall be registered; aref_cmd and aref_addr shall change only on rising edges.
REQ-023 ref_en held high continuously shall start exactly one sequence per request.
REQ-024 flag_init_end falling during a sequence shall not abort it; the sequence shall complete, then no further requests are issued until flag_init_end is high again.
REQ-025 Wait counters shall be sized for parameter maxima without overflow; T_RP >= 1 and T_RC >= 2 are required.

Reset
REQ-026 On rst high, immediately and independent of clk: state IDLE, timer 0, ref_req 0, flag_ref_end 0, aref_cmd 4'b0111, aref_addr 12'h000.
REQ-027 rst asserted mid-sequence shall abort it with outputs at reset values; after release, the timer restarts from 0 and no flag_ref_end is produced for the aborted sequence.

Verification
REQ-028 flag_init_end high from cycle 0, ref_en low -> ref_req rises after 750 cycles and stays high indefinitely with aref_cmd = NOP.
REQ-029 Grant one cycle after ref_req (defaults) -> PRECHARGE/12'h400 at cycle 0, AUTO REFRESH at cycles 3 and 10, flag_ref_end pulse at cycle 17, NOP elsewhere.
REQ-030 ref_en tied high -> one sequence every 750 cycles, never back-to-back, ref_req high for exactly one cycle each time.
REQ-031 Grant withheld for 1600 cycles -> single pending request, single sequence after grant, next ref_req set by the next timer expiry.
REQ-032 rst pulsed at cycle 5 of a sequence -> aref_cmd 4'b0111 and ref_req 0 asynchronously, no flag_ref_end, next ref_req 750 cycles after release.
REQ-033 flag_init_end low -> no ref_req for 2000 cycles; raised -> first ref_req 750 cycles later.
